// File: rtl/dcm_ctrl_pkg.sv
// Shared definitions for the DCM lock supervisor: state encoding and default timing.
package dcm_ctrl_pkg;

    // state  | meaning
    // HOLD   | dcm_reset asserted, counting out the reset pulse width
    // WAIT   | DCM out of reset, waiting for synchronized locked (with timeout)
    // STABLE | locked seen, requiring it to stay up for the qualification window
    // RUN    | downstream reset released, monitoring for lock loss
    // FAIL   | retries exhausted, DCM held in reset until restart or reset_n
    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    localparam int DEF_RST_HOLD_CYCLES = 8;
    localparam int DEF_LOCK_TIMEOUT    = 50000;
    localparam int DEF_STABLE_CYCLES   = 256;
    localparam int DEF_MAX_RETRY       = 7;
    localparam int DEF_CNT_WIDTH       = 16;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level signals, resets to 0.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Capture into the metastability stage, then retime once more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dcm_lock_ctrl.sv
// DCM reset/lock supervisor. Sequences DCM reset, waits for lock with timeout and
// retry limit, qualifies lock stability, then releases the downstream reset.
//
// state  | meaning
// HOLD   | dcm_reset high for RST_HOLD_CYCLES
// WAIT   | waiting for lk, times out after LOCK_TIMEOUT cycles
// STABLE | lk must hold for STABLE_CYCLES before RUN
// RUN    | sys_reset low, lock_ok high, watching for lock loss
// FAIL   | sticky until restart or reset_n
module dcm_lock_ctrl
    import dcm_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY       = DEF_MAX_RETRY,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       clkin_stopped,
    input  logic       clkfx_stopped,
    input  logic       restart,
    output logic       dcm_reset,
    output logic       sys_reset,
    output logic       lock_ok,
    output logic       lock_lost,
    output logic       fail,
    output logic [3:0] retry_cnt
);

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;

    logic [2:0]           pins_sync;
    logic                 lk;
    logic                 ci_stop;
    logic                 fx_stop;
    state_t               state;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [3:0]           retry_d;
    logic [3:0]           retry_inc;
    logic                 lost_d;
    logic                 counting;

    sync2 #(.WIDTH(3)) u_sync (
        .clk   (clk_in),
        .rst_n (reset_n),
        .d     ({clkfx_stopped, clkin_stopped, locked}),
        .q     (pins_sync)
    );

    assign lk        = pins_sync[0];
    assign ci_stop   = pins_sync[1];
    assign fx_stop   = pins_sync[2];
    assign retry_inc = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;
    assign counting  = (state == ST_HOLD) || (state == ST_WAIT) || (state == ST_STABLE);

    // Next state, retry count, lock-loss pulse and shared counter; restart overrides all.
    always_comb begin
        state_d = state;
        retry_d = retry_cnt;
        lost_d  = 1'b0;
        if (restart) begin
            state_d = ST_HOLD;
            retry_d = 4'd0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (lk) begin
                        state_d = ST_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        if ((MAX_RETRY != 0) && (32'(retry_inc) >= MAX_RETRY)) state_d = ST_FAIL;
                        else state_d = ST_HOLD;
                    end
                end
                ST_STABLE: begin
                    // A glitch sends us back to WAIT without charging a retry.
                    if (!lk || fx_stop) state_d = ST_WAIT;
                    else if (cnt == STABLE_LAST) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!lk || ci_stop || fx_stop) begin
                        state_d = ST_HOLD;
                        lost_d  = 1'b1;
                    end
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_HOLD;
            endcase
        end

        cnt_d = cnt;
        if (restart || (state_d != state)) cnt_d = '0;
        else if (counting && (cnt != CNT_MAX)) cnt_d = cnt + 1'b1;
    end

    // State, counter and outputs; outputs are decoded from the next state so they
    // change on the same edge as the transition.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            retry_cnt <= 4'd0;
            dcm_reset <= 1'b1;
            sys_reset <= 1'b1;
            lock_ok   <= 1'b0;
            lock_lost <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            retry_cnt <= retry_d;
            dcm_reset <= (state_d == ST_HOLD) || (state_d == ST_FAIL);
            sys_reset <= (state_d != ST_RUN);
            lock_ok   <= (state_d == ST_RUN);
            lock_lost <= lost_d;
            fail      <= (state_d == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_dcm_lock_ctrl.sv
// Self-checking bench for dcm_lock_ctrl. Expected event times come from a timing
// model of the sequence: the DCM reset pulse width, retry timeouts, and the rule
// that sys_reset falls STABLE+1 cycles after both WAIT is entered and a rise of
// locked has crossed the 2-flop synchronizer.
module tb_dcm_lock_ctrl;

    localparam int HOLD   = 8;
    localparam int TMO    = 1000;
    localparam int STABLE = 256;
    localparam int RETRY  = 3;

    logic       clk_in = 1'b0;
    logic       reset_n = 1'b0;
    logic       locked = 1'b0;
    logic       clkin_stopped = 1'b0;
    logic       clkfx_stopped = 1'b0;
    logic       restart = 1'b0;
    logic       dcm_reset;
    logic       sys_reset;
    logic       lock_ok;
    logic       lock_lost;
    logic       fail;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;

    dcm_lock_ctrl #(
        .RST_HOLD_CYCLES (HOLD),
        .LOCK_TIMEOUT    (TMO),
        .STABLE_CYCLES   (STABLE),
        .MAX_RETRY       (RETRY),
        .CNT_WIDTH       (16)
    ) dut (
        .clk_in        (clk_in),
        .reset_n       (reset_n),
        .locked        (locked),
        .clkin_stopped (clkin_stopped),
        .clkfx_stopped (clkfx_stopped),
        .restart       (restart),
        .dcm_reset     (dcm_reset),
        .sys_reset     (sys_reset),
        .lock_ok       (lock_ok),
        .lock_lost     (lock_lost),
        .fail          (fail),
        .retry_cnt     (retry_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
        ecnt++;
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return dcm_reset;
            1:       return sys_reset;
            default: return fail;
        endcase
    endfunction

    // Returns the edge index at which the selected output first shows val, or -1.
    task automatic wait_for(input int w, input logic val, input int budget, output int n);
        n = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sel(w) === val) begin
                n = ecnt;
                break;
            end
        end
    endtask

    function automatic int exp_sys_fall(input int dcm_fall, input int lock_rise);
        int seen;
        seen = (lock_rise + 2 > dcm_fall) ? lock_rise + 2 : dcm_fall;
        return seen + 1 + STABLE;
    endfunction

    task automatic do_reset(input logic lk_level);
        reset_n = 1'b0;
        locked = lk_level;
        clkin_stopped = 1'b0;
        clkfx_stopped = 1'b0;
        restart = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        ecnt = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++; if (dcm_reset !== 1'b1) begin errors++; $display("FAIL reset_dcm got %b want 1", dcm_reset); end
        checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL reset_sys got %b want 1", sys_reset); end
        checks++; if (lock_ok !== 1'b0 || lock_lost !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b%b want 000", lock_ok, lock_lost, fail); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL reset_retry got %0d want 0", retry_cnt); end
    endtask

    task automatic test_powerup();
        int n, lat;
        for (int r = 0; r < 3; r++) begin
            do_reset(1'b0);
            lat = $urandom_range(3, 400);
            wait_for(0, 1'b0, 50, n);
            checks++; if (n !== HOLD) begin errors++; $display("FAIL pu_dcm_fall got %0d want %0d", n, HOLD); end
            repeat (lat) tick();
            locked = 1'b1;
            checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL pu_sys_early got %b want 1", sys_reset); end
            wait_for(1, 1'b0, 1000, n);
            checks++; if (n !== exp_sys_fall(HOLD, HOLD + lat)) begin errors++; $display("FAIL pu_sys_fall L=%0d got %0d want %0d", lat, n, exp_sys_fall(HOLD, HOLD + lat)); end
            checks++; if (lock_ok !== 1'b1 || retry_cnt !== 4'd0 || dcm_reset !== 1'b0) begin errors++; $display("FAIL pu_run got ok=%b retry=%0d dcm=%b want 1 0 0", lock_ok, retry_cnt, dcm_reset); end
        end
    endtask

    task automatic test_retry_fail();
        int n, t, fall_e, rise_e;
        do_reset(1'b0);
        t = 0;
        for (int a = 1; a <= RETRY; a++) begin
            fall_e = t + HOLD;
            rise_e = fall_e + TMO;
            wait_for(0, 1'b0, 100, n);
            checks++; if (n !== fall_e) begin errors++; $display("FAIL rt_fall%0d got %0d want %0d", a, n, fall_e); end
            wait_for(0, 1'b1, TMO + 100, n);
            checks++; if (n !== rise_e) begin errors++; $display("FAIL rt_rise%0d got %0d want %0d", a, n, rise_e); end
            checks++; if (retry_cnt !== 4'(a)) begin errors++; $display("FAIL rt_cnt%0d got %0d want %0d", a, retry_cnt, a); end
            checks++; if (fail !== (a == RETRY)) begin errors++; $display("FAIL rt_fail%0d got %b want %b", a, fail, a == RETRY); end
            t = rise_e;
        end
        repeat (40) tick();
        checks++; if (dcm_reset !== 1'b1 || fail !== 1'b1 || retry_cnt !== 4'd3 || sys_reset !== 1'b1) begin errors++; $display("FAIL rt_sticky got dcm=%b fail=%b retry=%0d sys=%b want 1 1 3 1", dcm_reset, fail, retry_cnt, sys_reset); end
    endtask

    task automatic test_restart_from_fail();
        int n, r, lat;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        r = ecnt;
        checks++; if (fail !== 1'b0 || retry_cnt !== 4'd0 || dcm_reset !== 1'b1) begin errors++; $display("FAIL rs_clear got fail=%b retry=%0d dcm=%b want 0 0 1", fail, retry_cnt, dcm_reset); end
        wait_for(0, 1'b0, 50, n);
        checks++; if (n !== r + HOLD) begin errors++; $display("FAIL rs_dcm_fall got %0d want %0d", n, r + HOLD); end
        lat = $urandom_range(3, 400);
        repeat (lat) tick();
        locked = 1'b1;
        wait_for(1, 1'b0, 1000, n);
        checks++; if (n !== exp_sys_fall(r + HOLD, r + HOLD + lat)) begin errors++; $display("FAIL rs_sys_fall got %0d want %0d", n, exp_sys_fall(r + HOLD, r + HOLD + lat)); end
        checks++; if (lock_ok !== 1'b1) begin errors++; $display("FAIL rs_lock_ok got %b want 1", lock_ok); end
    endtask

    task automatic test_lock_lost();
        int n, k;
        for (int w = 0; w < 2; w++) begin
            k = ecnt;
            if (w == 0) locked = 1'b0; else clkin_stopped = 1'b1;
            tick();
            locked = 1'b1;
            clkin_stopped = 1'b0;
            tick();
            checks++; if (lock_lost !== 1'b0 || sys_reset !== 1'b0) begin errors++; $display("FAIL ll_early%0d got lost=%b sys=%b want 0 0", w, lock_lost, sys_reset); end
            tick();
            checks++; if (lock_lost !== 1'b1 || sys_reset !== 1'b1 || lock_ok !== 1'b0 || dcm_reset !== 1'b1) begin errors++; $display("FAIL ll_pulse%0d got lost=%b sys=%b ok=%b dcm=%b want 1 1 0 1", w, lock_lost, sys_reset, lock_ok, dcm_reset); end
            tick();
            checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL ll_width%0d got %b want 0", w, lock_lost); end
            wait_for(0, 1'b0, 50, n);
            checks++; if (n !== k + 3 + HOLD) begin errors++; $display("FAIL ll_dcm_fall%0d got %0d want %0d", w, n - k, 3 + HOLD); end
            wait_for(1, 1'b0, 1000, n);
            checks++; if (n !== exp_sys_fall(k + 3 + HOLD, k + 1)) begin errors++; $display("FAIL ll_sys_fall%0d got %0d want %0d", w, n, exp_sys_fall(k + 3 + HOLD, k + 1)); end
            checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL ll_retry%0d got %0d want 0", w, retry_cnt); end
        end
    endtask

    task automatic test_restart_in_run();
        int n, k, lat;
        k = ecnt;
        locked = 1'b0;
        tick();
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++; if (sys_reset !== 1'b1 || lock_lost !== 1'b0 || lock_ok !== 1'b0 || dcm_reset !== 1'b1) begin errors++; $display("FAIL rr_edge got sys=%b lost=%b ok=%b dcm=%b want 1 0 0 1", sys_reset, lock_lost, lock_ok, dcm_reset); end
        tick();
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL rr_no_lost got %b want 0", lock_lost); end
        wait_for(0, 1'b0, 50, n);
        checks++; if (n !== k + 3 + HOLD) begin errors++; $display("FAIL rr_dcm_fall got %0d want %0d", n - k, 3 + HOLD); end
        lat = $urandom_range(3, 200);
        repeat (lat) tick();
        locked = 1'b1;
        wait_for(1, 1'b0, 1000, n);
        checks++; if (n !== exp_sys_fall(k + 3 + HOLD, k + 3 + HOLD + lat)) begin errors++; $display("FAIL rr_sys_fall got %0d want %0d", n, exp_sys_fall(k + 3 + HOLD, k + 3 + HOLD + lat)); end
    endtask

    task automatic test_stable_glitch();
        int n, lat, s, off, len, rise2;
        for (int r = 0; r < 4; r++) begin
            do_reset(1'b0);
            lat = $urandom_range(3, 300);
            off = (r == 0) ? 198 : $urandom_range(0, 253);
            len = (r == 0) ? 5 : $urandom_range(1, 8);
            wait_for(0, 1'b0, 50, n);
            repeat (lat) tick();
            locked = 1'b1;
            s = HOLD + lat + 3;
            repeat (s + off - ecnt) tick();
            locked = 1'b0;
            repeat (len) tick();
            locked = 1'b1;
            rise2 = ecnt;
            checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL sg_sys_held%0d got %b want 1", r, sys_reset); end
            wait_for(1, 1'b0, 1000, n);
            checks++; if (n !== exp_sys_fall(HOLD, rise2)) begin errors++; $display("FAIL sg_sys_fall%0d off=%0d len=%0d got %0d want %0d", r, off, len, n, exp_sys_fall(HOLD, rise2)); end
            checks++; if (retry_cnt !== 4'd0 || lock_ok !== 1'b1) begin errors++; $display("FAIL sg_state%0d got retry=%0d ok=%b want 0 1", r, retry_cnt, lock_ok); end
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset(1'b1);
        wait_for(0, 1'b0, 50, n);
        repeat (60) tick();
        checks++; if (dcm_reset !== 1'b0 || sys_reset !== 1'b1) begin errors++; $display("FAIL ar_pre_stable got dcm=%b sys=%b want 0 1", dcm_reset, sys_reset); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (dcm_reset !== 1'b1 || sys_reset !== 1'b1 || lock_ok !== 1'b0 || fail !== 1'b0 || retry_cnt !== 4'd0) begin errors++; $display("FAIL ar_stable got dcm=%b sys=%b ok=%b fail=%b retry=%0d", dcm_reset, sys_reset, lock_ok, fail, retry_cnt); end
        @(posedge clk_in);
        #1 reset_n = 1'b1;
        ecnt = 0;
        wait_for(0, 1'b0, 50, n);
        checks++; if (n !== HOLD) begin errors++; $display("FAIL ar_dcm_fall1 got %0d want %0d", n, HOLD); end
        wait_for(1, 1'b0, 1000, n);
        checks++; if (n !== exp_sys_fall(HOLD, 0)) begin errors++; $display("FAIL ar_sys_fall got %0d want %0d", n, exp_sys_fall(HOLD, 0)); end
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (dcm_reset !== 1'b1 || sys_reset !== 1'b1 || lock_ok !== 1'b0 || lock_lost !== 1'b0) begin errors++; $display("FAIL ar_run got dcm=%b sys=%b ok=%b lost=%b", dcm_reset, sys_reset, lock_ok, lock_lost); end
        @(posedge clk_in);
        #1 reset_n = 1'b1;
        ecnt = 0;
        wait_for(0, 1'b0, 50, n);
        checks++; if (n !== HOLD) begin errors++; $display("FAIL ar_dcm_fall2 got %0d want %0d", n, HOLD); end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_retry_fail();
        test_restart_from_fail();
        test_lock_lost();
        test_restart_in_run();
        test_stable_glitch();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
